// File: rtl/evt_fanout_sched_pkg.sv
// Shared types and helpers for the event fan-in scheduler and its arbiter.
package evt_fanout_sched_pkg;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int INSTANCES_DEF = 20;
  localparam int TS_W_DEF      = 16;

  typedef logic [idx_w(INSTANCES_DEF)-1:0] idx_t;
  typedef logic [TS_W_DEF-1:0]             ts_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

endpackage

// File: rtl/evt_fanout_sched_rr_pick.sv
// Combinational circular find-first-set: returns the first set request
// strictly after 'last', wrapping from N-1 to 0. Generic, reusable arbiter core.
module rr_pick #(
  parameter int N  = 20,
  parameter int IW = 5
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  int          cand;
  logic [IW-1:0] cand_idx;

  // Scan offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = N; k >= 1; k--) begin
      cand     = (int'(last) + k) % N;
      cand_idx = IW'(cand);
      if (req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/evt_fanout_sched.sv
// Round-robin event scheduler: one pending slot per instance, events handed
// out one at a time on a valid/ready channel, lost events counted.
// Optional per-event timestamps: define EVT_FANOUT_SCHED_TIMESTAMP_EN.
module evt_fanout_sched
  import evt_fanout_sched_pkg::*;
#(
  parameter int INSTANCES = 20,
  parameter int CNT_W     = 8,
  parameter int TS_W      = 16,
  localparam int IDX_W    = idx_w(INSTANCES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INSTANCES-1:0] evt_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_idx,
  output logic [INSTANCES-1:0] pending_o,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic                 busy
`ifdef EVT_FANOUT_SCHED_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]      out_ts
`endif
);

  localparam int              SUM_W   = CNT_W + IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Elaboration guard on nonsensical configurations.
  if (INSTANCES < 2 || TS_W < 1) begin : g_bad_cfg
    $error("evt_fanout_sched: INSTANCES must be >= 2 and TS_W >= 1");
  end

  state_e                 state_reg, state_next;
  logic [INSTANCES-1:0]   pending_reg, pending_next;
  logic [INSTANCES-1:0]   load_mask, drop_vec;
  logic [IDX_W-1:0]       out_idx_reg, last_grant_reg, pick_idx;
  logic                   pick_found, load;
  logic [CNT_W-1:0]       drop_cnt_reg, drop_cnt_next;
  logic [SUM_W-1:0]       drop_sum;

  rr_pick #(
    .N  (INSTANCES),
    .IW (IDX_W)
  ) u_pick (
    .req   (pending_reg),
    .last  (last_grant_reg),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // A winner is loaded whenever the output slot is free or is being consumed.
  always_comb begin
    load = pick_found && ((state_reg == IDLE) || out_ready);
  end

  // Per-instance pending update: a load frees the slot, so a same-edge event
  // just re-arms it; an event hitting an occupied, unloaded slot is lost.
  for (genvar gi = 0; gi < INSTANCES; gi++) begin : g_slot
    assign load_mask[gi]    = load && (pick_idx == IDX_W'(gi));
    assign drop_vec[gi]     = evt_i[gi] && pending_reg[gi] && !load_mask[gi];
    assign pending_next[gi] = (pending_reg[gi] && !load_mask[gi]) || evt_i[gi];
  end

  // Add this cycle's drop popcount, saturating at the counter maximum.
  always_comb begin
    drop_sum = SUM_W'(drop_cnt_reg);
    for (int i = 0; i < INSTANCES; i++) begin
      drop_sum = drop_sum + SUM_W'(drop_vec[i]);
    end
    drop_cnt_next = (drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: stay presenting while there is more work behind a handshake.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pick_found) state_next = PRESENT;
      PRESENT: if (out_ready && !pick_found) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    out_valid = (state_reg == PRESENT);
  end

  // Pending flags, drop counter and the presented index / round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_reg    <= '0;
      drop_cnt_reg   <= '0;
      out_idx_reg    <= '0;
      last_grant_reg <= IDX_W'(INSTANCES - 1);
    end else begin
      pending_reg  <= pending_next;
      drop_cnt_reg <= drop_cnt_next;
      if (load) begin
        out_idx_reg    <= pick_idx;
        last_grant_reg <= pick_idx;
      end
    end
  end

  assign out_idx   = out_idx_reg;
  assign pending_o = pending_reg;
  assign drop_cnt  = drop_cnt_reg;
  assign busy      = out_valid || (|pending_reg);

`ifdef EVT_FANOUT_SCHED_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt_reg;
  logic [TS_W-1:0] out_ts_reg;
  logic [TS_W-1:0] stamp_reg [INSTANCES];

  // Free-running time base and the stamp travelling with the presented index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_cnt_reg <= '0;
      out_ts_reg <= '0;
    end else begin
      ts_cnt_reg <= ts_cnt_reg + 1'b1;
      if (load) begin
        out_ts_reg <= stamp_reg[pick_idx];
      end
    end
  end

  // Stamp only freshly armed slots; a dropped event keeps the older time.
  always_ff @(posedge clk) begin
    for (int i = 0; i < INSTANCES; i++) begin
      if (evt_i[i] && !drop_vec[i]) begin
        stamp_reg[i] <= ts_cnt_reg;
      end
    end
  end

  assign out_ts = out_ts_reg;
`endif

endmodule

// File: tb/tb_evt_fanout_sched.sv
// Directed bench for evt_fanout_sched: a vector table plus hand sequences for
// reset-in-flight, saturation and (when enabled) timestamps.
module tb_evt_fanout_sched;

  localparam int N     = 20;
  localparam int CNT_W = 2;
  localparam int TS_W  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  evt_i = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [4:0]    out_idx;
  logic [N-1:0]  pending_o;
  logic [CNT_W-1:0] drop_cnt;
  logic          busy;
`ifdef EVT_FANOUT_SCHED_TIMESTAMP_EN
  logic [TS_W-1:0] out_ts;
`endif

  int total = 0;
  int bad   = 0;

  evt_fanout_sched #(
    .INSTANCES (N),
    .CNT_W     (CNT_W),
    .TS_W      (TS_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .evt_i     (evt_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .pending_o (pending_o),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
`ifdef EVT_FANOUT_SCHED_TIMESTAMP_EN
    ,
    .out_ts    (out_ts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst_n;
    logic [N-1:0] evt;
    logic         rdy;
    logic         exp_valid;
    logic [4:0]   exp_idx;
    logic [N-1:0] exp_pend;
    logic [CNT_W-1:0] exp_drop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [N-1:0] e, logic rd, logic v,
                              logic [4:0] ix, logic [N-1:0] p, logic [CNT_W-1:0] d);
    vec_t t;
    t.rst_n = r; t.evt = e; t.rdy = rd; t.exp_valid = v;
    t.exp_idx = ix; t.exp_pend = p; t.exp_drop = d;
    return t;
  endfunction

  function automatic logic [N-1:0] b(int i);
    logic [N-1:0] m;
    m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply one vector across one edge and compare the post-edge outputs.
  task automatic run_vec(vec_t v, string name);
    logic exp_busy;
    rst_n     = v.rst_n;
    evt_i     = v.evt;
    out_ready = v.rdy;
    step();
    exp_busy = v.exp_valid || (|v.exp_pend);
    check({name, ".valid"}, 32'(out_valid), 32'(v.exp_valid));
    if (v.exp_valid || !v.rst_n) check({name, ".idx"}, 32'(out_idx), 32'(v.exp_idx));
    check({name, ".pend"}, 32'(pending_o), 32'(v.exp_pend));
    check({name, ".drop"}, 32'(drop_cnt), 32'(v.exp_drop));
    check({name, ".busy"}, 32'(busy), 32'(exp_busy));
    $display("vec %s: rst_n=%0b evt=%05h rdy=%0b -> valid=%0b idx=%0d pend=%05h drop=%0d busy=%0b",
             name, v.rst_n, v.evt, v.rdy, out_valid, out_idx, pending_o, drop_cnt, busy);
  endtask

  initial begin
    logic [N-1:0] all1;
    all1 = '1;

    // Reset and single event: valid two edges after the pulse, then idle.
    vecs.push_back(mk(0, '0,    0, 0, 0,  '0,    0));
    vecs.push_back(mk(1, b(3),  1, 0, 0,  b(3),  0));
    vecs.push_back(mk(1, '0,    1, 1, 3,  '0,    0));
    vecs.push_back(mk(1, '0,    1, 0, 0,  '0,    0));
    // Backpressure on instance 5: first repeat re-arms, second is dropped.
    vecs.push_back(mk(1, b(5),  0, 0, 0,  b(5),  0));
    vecs.push_back(mk(1, '0,    0, 1, 5,  '0,    0));
    vecs.push_back(mk(1, b(5),  0, 1, 5,  b(5),  0));
    vecs.push_back(mk(1, b(5),  0, 1, 5,  b(5),  1));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(1, '0, 0, 1, 5, b(5), 1));
    vecs.push_back(mk(1, '0,    1, 1, 5,  '0,    1));
    vecs.push_back(mk(1, '0,    1, 0, 0,  '0,    1));
    // Fairness wrap: after granting 19, instance 0 beats 19.
    vecs.push_back(mk(1, b(19), 0, 0, 0,  b(19), 1));
    vecs.push_back(mk(1, '0,    0, 1, 19, '0,    1));
    vecs.push_back(mk(1, b(0) | b(19), 0, 1, 19, b(0) | b(19), 1));
    vecs.push_back(mk(1, '0,    1, 1, 0,  b(19), 1));
    vecs.push_back(mk(1, '0,    1, 1, 19, '0,    1));
    vecs.push_back(mk(1, '0,    1, 0, 0,  '0,    1));
    // Round robin over all instances, one grant per cycle.
    vecs.push_back(mk(1, all1,  1, 0, 0,  all1,  1));
    for (int k = 0; k < N; k++) vecs.push_back(mk(1, '0, 1, 1, 5'(k), all1 << (k + 1), 1));
    vecs.push_back(mk(1, '0,    1, 0, 0,  '0,    1));

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("t%0d", i));
    end

    // Reset while presenting with four instances still pending.
    run_vec(mk(1, b(1) | b(2) | b(3) | b(4) | b(6), 0, 0, 0, b(1) | b(2) | b(3) | b(4) | b(6), 1), "rm0");
    run_vec(mk(1, '0, 0, 1, 1, b(2) | b(3) | b(4) | b(6), 1), "rm1");
    run_vec(mk(0, '0, 0, 0, 0, '0, 0), "rm_rst");
    run_vec(mk(1, b(0) | b(10), 0, 0, 0, b(0) | b(10), 0), "rm2");
    run_vec(mk(1, '0, 1, 1, 0,  b(10), 0), "rm3");
    run_vec(mk(1, '0, 1, 1, 10, '0,    0), "rm4");
    run_vec(mk(1, '0, 1, 0, 0,  '0,    0), "rm5");

    // Same-edge re-arm on load, multi-drop popcount and saturation (6 drops).
    run_vec(mk(1, b(0) | b(1) | b(2), 0, 0, 0, b(0) | b(1) | b(2), 0), "sat0");
    run_vec(mk(1, b(0), 0, 1, 0, b(0) | b(1) | b(2), 0), "sat1");
    run_vec(mk(1, b(1) | b(2), 0, 1, 0, b(0) | b(1) | b(2), 2), "sat2");
    run_vec(mk(1, b(0) | b(1) | b(2) | b(3), 0, 1, 0, b(0) | b(1) | b(2) | b(3), 3), "sat3");
    run_vec(mk(1, b(1), 0, 1, 0, b(0) | b(1) | b(2) | b(3), 3), "sat4");
    run_vec(mk(1, '0, 1, 1, 1, b(0) | b(2) | b(3), 3), "dr0");
    run_vec(mk(1, '0, 1, 1, 2, b(0) | b(3), 3), "dr1");
    run_vec(mk(1, '0, 1, 1, 3, b(0), 3), "dr2");
    run_vec(mk(1, '0, 1, 1, 0, '0, 3), "dr3");
    run_vec(mk(1, '0, 1, 0, 0, '0, 3), "dr4");

`ifdef EVT_FANOUT_SCHED_TIMESTAMP_EN
    // Counter is 0 after the reset edge and counts every later edge.
    rst_n = 1'b0; evt_i = '0; out_ready = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (5) step();
    evt_i = b(9); step();
    evt_i = '0;   step();
    check("ts9.idx", 32'(out_idx), 32'd9);
    check("ts9.ts", 32'(out_ts), 32'd5);
    $display("ts: idx=%0d ts=%0d", out_idx, out_ts);
    evt_i = b(2); step();
    evt_i = '0;   step();
    evt_i = b(2); step();
    check("ts.drop", 32'(drop_cnt), 32'd1);
    evt_i = '0; out_ready = 1'b1; step();
    check("ts2.idx", 32'(out_idx), 32'd2);
    check("ts2.ts", 32'(out_ts), 32'd7);
    $display("ts: idx=%0d ts=%0d", out_idx, out_ts);
    out_ready = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
